// File: rtl/alu_ctrl_decoder.sv
// Registered instruction-to-control decoder for the 24-bit datapath.
// Decodes are held in a 2-entry skid queue; illegal instructions are counted (saturating).
module alu_ctrl_decoder #(
    parameter int INSTR_W = 24,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2:0]         alu_sel,
    output logic               alu_src,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               branch,
    output logic               illegal,
    output logic [CNT_W-1:0]   illegal_count
);

    typedef struct packed {
        logic [2:0] alu_sel;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       illegal;
    } dec_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic dec_t decode(input logic [3:0] opcode, input logic [3:0] funct);
        dec_t d;
        d = '0;
        case (opcode)
            4'b0000: begin
                d.reg_write = 1'b1;
                case (funct)
                    4'b0000: d.alu_sel = 3'b000;
                    4'b0001: d.alu_sel = 3'b001;
                    4'b0010: d.alu_sel = 3'b010;
                    4'b0110: d.alu_sel = 3'b110;
                    4'b0101: d.alu_sel = 3'b101;
                    4'b0111: d.alu_sel = 3'b111;
                    default: begin
                        d = '0;
                        d.illegal = 1'b1;
                    end
                endcase
            end
            4'b0100: begin d.alu_sel = 3'b010; d.alu_src = 1'b1; d.reg_write = 1'b1; end
            4'b0101: begin d.alu_sel = 3'b000; d.alu_src = 1'b1; d.reg_write = 1'b1; end
            4'b0110: begin d.alu_sel = 3'b001; d.alu_src = 1'b1; d.reg_write = 1'b1; end
            4'b0111: begin d.alu_sel = 3'b101; d.alu_src = 1'b1; d.reg_write = 1'b1; end
            4'b1000: begin
                d.alu_sel    = 3'b010;
                d.alu_src    = 1'b1;
                d.mem_read   = 1'b1;
                d.mem_to_reg = 1'b1;
                d.reg_write  = 1'b1;
            end
            4'b1001: begin d.alu_sel = 3'b010; d.alu_src = 1'b1; d.mem_write = 1'b1; end
            4'b1010: begin d.alu_sel = 3'b110; d.branch = 1'b1; end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic [1:0] count_r;
    dec_t       head_r;
    dec_t       tail_r;
    logic [CNT_W-1:0] illegal_count_r;
    dec_t       dec_s;
    logic       push_s;
    logic       pop_s;

    assign dec_s     = decode(instr[INSTR_W-1 -: 4], instr[3:0]);
    assign in_ready  = (count_r < 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Skid queue: head is always the oldest decode and reads all-zero when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 2'd0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= dec_s;
                    end else begin
                        tail_r <= dec_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= (count_r == 2'd2) ? tail_r : dec_t'('0);
                    tail_r  <= '0;
                    count_r <= count_r - 2'd1;
                end
                // Simultaneous push/pop only happens at occupancy 1: replace head.
                2'b11: head_r <= dec_s;
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

    // Saturating count of illegal instructions, bumped on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_count_r <= '0;
        end else if (push_s && dec_s.illegal && (illegal_count_r != CNT_MAX)) begin
            illegal_count_r <= illegal_count_r + CNT_ONE;
        end else begin
            illegal_count_r <= illegal_count_r;
        end
    end

    assign alu_sel       = head_r.alu_sel;
    assign alu_src       = head_r.alu_src;
    assign reg_write     = head_r.reg_write;
    assign mem_read      = head_r.mem_read;
    assign mem_write     = head_r.mem_write;
    assign mem_to_reg    = head_r.mem_to_reg;
    assign branch        = head_r.branch;
    assign illegal       = head_r.illegal;
    assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Directed self-checking bench for alu_ctrl_decoder.
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_sel;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, illegal;
    logic [7:0]  illegal_count;

    int vectors = 0;
    int miscompares = 0;

    alu_ctrl_decoder #(.INSTR_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .alu_sel(alu_sel), .alu_src(alu_src),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 24'h0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        vectors++; if (illegal_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", illegal_count); end
        vectors++; if ({alu_sel, alu_src, reg_write, illegal} !== 6'b0) begin miscompares++; $display("FAIL reset_outputs: got %0h want 0", {alu_sel, alu_src, reg_write, illegal}); end
    endtask

    task automatic test_basic_add();
        instr = 24'h000002; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %0b want 1", out_valid); end
        vectors++; if ({alu_sel, reg_write, alu_src} !== {3'b010, 1'b1, 1'b0}) begin miscompares++; $display("FAIL add_decode: got %0h want %0h", {alu_sel, reg_write, alu_src}, {3'b010, 1'b1, 1'b0}); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: got %0b want 0", out_valid); end
        vectors++; if ({alu_sel, reg_write} !== 4'b0) begin miscompares++; $display("FAIL add_zero_when_empty: got %0h want 0", {alu_sel, reg_write}); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        instr = 24'h400000; in_valid = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_occ1: got %0b want 1", in_ready); end
        instr = 24'h800000;
        tick();
        in_valid = 1'b0;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready_full: got %0b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({out_valid, alu_sel, alu_src, mem_read} !== {1'b1, 3'b010, 1'b1, 1'b0}) begin miscompares++; $display("FAIL stall_hold_addi: got %0h want %0h", {out_valid, alu_sel, alu_src, mem_read}, {1'b1, 3'b010, 1'b1, 1'b0}); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        vectors++; if ({out_valid, mem_read, mem_to_reg, reg_write, in_ready} !== 5'b11111) begin miscompares++; $display("FAIL stall_lw: got %0b want 11111", {out_valid, mem_read, mem_to_reg, reg_write, in_ready}); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] functs [4] = '{4'b0001, 4'b0101, 4'b0110, 4'b0111};
        logic [2:0] sels   [4] = '{3'b001, 3'b101, 3'b110, 3'b111};
        out_ready = 1'b0; instr = 24'h000000; in_valid = 1'b1;
        tick();
        vectors++; if ({out_valid, alu_sel} !== {1'b1, 3'b000}) begin miscompares++; $display("FAIL b2b_and: got %0h want 8", {out_valid, alu_sel}); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = {20'h00000, functs[i]};
            tick();
            vectors++; if ({out_valid, in_ready, alu_sel} !== {1'b1, 1'b1, sels[i]}) begin miscompares++; $display("FAIL b2b_step%0d: got %0h want %0h", i, {out_valid, in_ready, alu_sel}, {1'b1, 1'b1, sels[i]}); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_itype();
        logic [3:0] ops  [3] = '{4'b0101, 4'b0110, 4'b0111};
        logic [2:0] sels [3] = '{3'b000, 3'b001, 3'b101};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = {ops[i], 20'h00000}; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            vectors++; if ({out_valid, alu_sel, alu_src, reg_write, mem_write, branch} !== {1'b1, sels[i], 4'b1100}) begin miscompares++; $display("FAIL itype_op%0h: got %0h want %0h", ops[i], {out_valid, alu_sel, alu_src, reg_write, mem_write, branch}, {1'b1, sels[i], 4'b1100}); end
            tick();
        end
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 24'hF00000;
        tick();
        vectors++; if ({illegal, alu_sel, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch} !== {1'b1, 9'b0}) begin miscompares++; $display("FAIL illegal_opcode: got %0h want %0h", {illegal, alu_sel, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}, {1'b1, 9'b0}); end
        vectors++; if (illegal_count !== 8'd1) begin miscompares++; $display("FAIL illegal_count1: got %0d want 1", illegal_count); end
        instr = 24'h00000F;
        tick();
        vectors++; if ({illegal, alu_sel, reg_write} !== {1'b1, 4'b0}) begin miscompares++; $display("FAIL illegal_funct: got %0h want 10", {illegal, alu_sel, reg_write}); end
        vectors++; if (illegal_count !== 8'd2) begin miscompares++; $display("FAIL illegal_count2: got %0d want 2", illegal_count); end
        instr = 24'hB00000;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        vectors++; if (illegal_count !== 8'd255) begin miscompares++; $display("FAIL illegal_saturate: got %0d want 255", illegal_count); end
        tick(); tick();
        vectors++; if (illegal_count !== 8'd255) begin miscompares++; $display("FAIL illegal_hold: got %0d want 255", illegal_count); end
    endtask

    task automatic test_reset_override();
        out_ready = 1'b0; in_valid = 1'b1; instr = 24'h400000;
        tick(); tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ovr_full: got %0b want 0", in_ready); end
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        vectors++; if ({out_valid, in_ready} !== 2'b01) begin miscompares++; $display("FAIL rst_ovr_flags: got %0b want 01", {out_valid, in_ready}); end
        vectors++; if (illegal_count !== 8'd0) begin miscompares++; $display("FAIL rst_ovr_count: got %0d want 0", illegal_count); end
        vectors++; if ({alu_sel, alu_src, reg_write} !== 5'b0) begin miscompares++; $display("FAIL rst_ovr_outputs: got %0h want 0", {alu_sel, alu_src, reg_write}); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_ovr_no_capture: got %0b want 0", out_valid); end
    endtask

    task automatic test_branch_store();
        out_ready = 1'b0; in_valid = 1'b1; instr = 24'hA00000;
        tick();
        instr = 24'h900000;
        tick();
        in_valid = 1'b0;
        vectors++; if ({alu_sel, branch, reg_write, alu_src, mem_write} !== {3'b110, 4'b1000}) begin miscompares++; $display("FAIL beq_decode: got %0h want %0h", {alu_sel, branch, reg_write, alu_src, mem_write}, {3'b110, 4'b1000}); end
        out_ready = 1'b1;
        tick();
        vectors++; if ({out_valid, alu_sel, mem_write, reg_write, alu_src, branch} !== {1'b1, 3'b010, 4'b1010}) begin miscompares++; $display("FAIL sw_decode: got %0h want %0h", {out_valid, alu_sel, mem_write, reg_write, alu_src, branch}, {1'b1, 3'b010, 4'b1010}); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bs_drain: got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_stall();
        test_back_to_back();
        test_itype();
        test_illegal();
        test_reset_override();
        test_branch_store();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
